// File: rtl/bp_be_dcache_wbuf_sched.sv
// Data-SRAM port scheduler for the dcache.
// Arbitrates engine packets, tl-stage loads and write-buffer drains.
module bp_be_dcache_wbuf_sched #(
  parameter int starve_limit_p = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic engine_v_i,
  output logic engine_yumi_o,
  input  logic ld_v_i,
  output logic ld_grant_o,
  input  logic wbuf_v_i,
  input  logic wbuf_force_i,
  output logic wbuf_yumi_o,
  input  logic snoop_match_i,
  input  logic fence_v_i,
  output logic fence_done_o,
  output logic data_mem_v_o,
  output logic data_mem_w_o,
  output logic stall_o,
  output logic starved_o
);

  localparam int starve_width_lp =
    (starve_limit_p + 1 <= 2) ? 1 : $clog2(starve_limit_p + 1);
  localparam logic [starve_width_lp-1:0] lim_lp =
    starve_width_lp'(starve_limit_p);
  localparam logic [starve_width_lp-1:0] lim_m1_lp =
    starve_width_lp'(starve_limit_p - 1);

  typedef enum logic [1:0] {
    e_ready,
    e_drain,
    e_fence
  } state_e;

  state_e state_q, state_d;
  logic [starve_width_lp-1:0] cnt_q, cnt_d;

  logic eng_g, ld_g, wb_g, ld_ok, done;
  logic denied, trig;

  assign ld_ok = ld_v_i & ~snoop_match_i;

  // Same-cycle grant selection; priority depends on the mode.
  always_comb begin
    eng_g = 1'b0;
    ld_g  = 1'b0;
    wb_g  = 1'b0;
    if (reset_n_i) begin
      case (state_q)
        e_ready: begin
          if (engine_v_i)                    eng_g = 1'b1;
          else if (wbuf_v_i & wbuf_force_i)  wb_g  = 1'b1;
          else if (ld_ok)                    ld_g  = 1'b1;
          else if (wbuf_v_i)                 wb_g  = 1'b1;
        end
        e_drain: begin
          if (engine_v_i)     eng_g = 1'b1;
          else if (wbuf_v_i)  wb_g  = 1'b1;
          else if (ld_ok)     ld_g  = 1'b1;
        end
        e_fence: begin
          if (engine_v_i)     eng_g = 1'b1;
          else if (wbuf_v_i)  wb_g  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign denied = wbuf_v_i & ~wb_g;
  assign trig   = (state_q == e_ready) & denied
                & (cnt_q == lim_m1_lp);

  // Mode transitions, fence completion and starvation counting.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    if (!denied)
      cnt_d = '0;
    else if (cnt_q == lim_lp)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
    case (state_q)
      e_ready: begin
        if (fence_v_i) begin
          state_d = e_fence;
        end else if (trig) begin
          state_d = e_drain;
          cnt_d   = '0;
        end
      end
      e_drain: begin
        if (fence_v_i)      state_d = e_fence;
        else if (!wbuf_v_i) state_d = e_ready;
      end
      e_fence: begin
        if (!wbuf_v_i && !engine_v_i) begin
          done    = reset_n_i;
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign engine_yumi_o = eng_g;
  assign ld_grant_o    = ld_g;
  assign wbuf_yumi_o   = wb_g;
  assign fence_done_o  = done;
  assign data_mem_v_o  = eng_g | ld_g | wb_g;
  assign data_mem_w_o  = eng_g | wb_g;
  assign stall_o       = reset_n_i & ld_v_i & ~ld_g;
  assign starved_o     = reset_n_i & (state_q == e_drain);

`ifndef SYNTHESIS
  logic done_q;

  // Previous-cycle fence_done, for the no-back-to-back check.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) done_q <= 1'b0;
    else            done_q <= done;
  end

  // Protocol invariants of the scheduler outputs.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0({eng_g, ld_g, wb_g}))
        else $error("grants not exclusive");
      assert (!wb_g || wbuf_v_i)
        else $error("wbuf dequeued while empty");
      assert (!(done && done_q))
        else $error("fence_done on consecutive cycles");
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_dcache_wbuf_sched.sv
// Bench for the dcache data-SRAM port scheduler.
// Directed scenarios plus randomized traffic vs a reference model.
module tb_bp_be_dcache_wbuf_sched;

  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic eng_v = 0, ld_v = 0, wb_v = 0, wb_f = 0, snoop = 0, fence = 0;
  logic eng_y, ld_g, wb_y, fdone, mem_v, mem_w, stall, starved;

  int n_chk = 0;
  int n_pass = 0;

  // model: mode 0=ready 1=drain 2=fence; den = consecutive denials
  int m_mode = 0;
  int m_den = 0;

  logic [7:0] exp_v, act_v;

  always #5 clk = ~clk;

  bp_be_dcache_wbuf_sched #(.starve_limit_p(LIMIT)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .engine_v_i(eng_v), .engine_yumi_o(eng_y),
    .ld_v_i(ld_v), .ld_grant_o(ld_g),
    .wbuf_v_i(wb_v), .wbuf_force_i(wb_f), .wbuf_yumi_o(wb_y),
    .snoop_match_i(snoop),
    .fence_v_i(fence), .fence_done_o(fdone),
    .data_mem_v_o(mem_v), .data_mem_w_o(mem_w),
    .stall_o(stall), .starved_o(starved)
  );

  wire [7:0] dut_vec =
    {eng_y, ld_g, wb_y, mem_v, mem_w, stall, starved, fdone};

  // winner: 0 none, 1 engine, 2 load, 3 wbuf
  function automatic int winner();
    bit ld_ok = ld_v && !snoop;
    if (eng_v) return 1;
    if (m_mode == 0) begin
      if (wb_v && wb_f) return 3;
      if (ld_ok) return 2;
      if (wb_v) return 3;
    end else if (m_mode == 1) begin
      if (wb_v) return 3;
      if (ld_ok) return 2;
    end else begin
      if (wb_v) return 3;
    end
    return 0;
  endfunction

  function automatic logic [7:0] model_out();
    int w = winner();
    bit dn = (m_mode == 2) && !wb_v && !eng_v;
    return {w == 1, w == 2, w == 3, w != 0, w == 1 || w == 3,
            ld_v && w != 2, m_mode == 1, dn};
  endfunction

  task automatic model_adv();
    int w = winner();
    bit dn = (m_mode == 2) && !wb_v && !eng_v;
    if (wb_v && w != 3) m_den = (m_den < LIMIT) ? m_den + 1 : LIMIT;
    else m_den = 0;
    case (m_mode)
      0: if (fence) m_mode = 2;
         else if (m_den == LIMIT) begin m_mode = 1; m_den = 0; end
      1: if (fence) m_mode = 2;
         else if (!wb_v) m_mode = 0;
      default: if (dn) m_mode = 0;
    endcase
  endtask

  task automatic step(input logic e, l, w, f, s, fv);
    @(posedge clk);
    #1;
    eng_v = e; ld_v = l; wb_v = w; wb_f = f; snoop = s; fence = fv;
    #4;
    exp_v = model_out();
    act_v = dut_vec;
    model_adv();
  endtask

  task automatic test_reset();
    #2;
    eng_v = 1; ld_v = 1; wb_v = 1; wb_f = 1; fence = 1;
    #1;
    n_chk++;
    if (dut_vec !== 8'h00)
      $display("FAIL reset_outputs: got %b want %b", dut_vec, 8'h00);
    else n_pass++;
    eng_v = 0; ld_v = 0; wb_v = 0; wb_f = 0; fence = 0;
    @(negedge clk);
    reset_n = 1;
    m_mode = 0; m_den = 0;
    step(0, 1, 0, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0101_0000)
      $display("FAIL reset_first_ld: got %b want %b", act_v, 8'b0101_0000);
    else n_pass++;
  endtask

  task automatic test_engine_priority();
    step(1, 1, 1, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b1001_1100)
      $display("FAIL engine_prio: got %b want %b", act_v, 8'b1001_1100);
    else n_pass++;
    n_chk++;
    if (act_v !== exp_v)
      $display("FAIL engine_prio_model: got %b want %b", act_v, exp_v);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_starvation();
    for (int i = 0; i < LIMIT; i++) begin
      step(0, 1, 1, 0, 0, 0);
      n_chk++;
      if (act_v !== 8'b0101_0000)
        $display("FAIL starve_ld_c%0d: got %b want %b", i, act_v, 8'b0101_0000);
      else n_pass++;
    end
    step(0, 1, 1, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0011_1110)
      $display("FAIL starve_drain: got %b want %b", act_v, 8'b0011_1110);
    else n_pass++;
    step(0, 1, 0, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0101_0010)
      $display("FAIL starve_drain_exit: got %b want %b", act_v, 8'b0101_0010);
    else n_pass++;
    step(0, 1, 0, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0101_0000)
      $display("FAIL starve_ready: got %b want %b", act_v, 8'b0101_0000);
    else n_pass++;
  endtask

  task automatic test_force();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 0, 0);
      n_chk++;
      if (act_v !== 8'b0011_1100)
        $display("FAIL force_c%0d: got %b want %b", i, act_v, 8'b0011_1100);
      else n_pass++;
    end
    // counter must still be zero: 7 more denials do not starve
    for (int i = 0; i < LIMIT - 1; i++) step(0, 1, 1, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0101_0000)
      $display("FAIL force_cnt_zero: got %b want %b", act_v, 8'b0101_0000);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_snoop();
    step(0, 1, 0, 0, 1, 0);
    n_chk++;
    if (act_v !== 8'b0000_0100)
      $display("FAIL snoop_ld: got %b want %b", act_v, 8'b0000_0100);
    else n_pass++;
    step(0, 1, 1, 0, 1, 0);
    n_chk++;
    if (act_v !== 8'b0011_1100)
      $display("FAIL snoop_wb: got %b want %b", act_v, 8'b0011_1100);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fence();
    int dones = 0;
    step(0, 1, 1, 0, 0, 1);
    dones += int'(act_v[0]);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 0, 1);
      dones += int'(act_v[0]);
      n_chk++;
      if (act_v !== 8'b0011_1100)
        $display("FAIL fence_drain_c%0d: got %b want %b", i, act_v, 8'b0011_1100);
      else n_pass++;
    end
    step(0, 1, 0, 0, 0, 1);
    dones += int'(act_v[0]);
    n_chk++;
    if (act_v !== 8'b0000_0101)
      $display("FAIL fence_done: got %b want %b", act_v, 8'b0000_0101);
    else n_pass++;
    step(0, 1, 0, 0, 0, 0);
    dones += int'(act_v[0]);
    n_chk++;
    if (act_v !== 8'b0101_0000)
      $display("FAIL fence_ld_resume: got %b want %b", act_v, 8'b0101_0000);
    else n_pass++;
    n_chk++;
    if (dones !== 1)
      $display("FAIL fence_done_count: got %0d want 1", dones);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    n_chk++;
    if (act_v !== 8'b0011_1100)
      $display("FAIL areset_pre: got %b want %b", act_v, 8'b0011_1100);
    else n_pass++;
    #2;
    reset_n = 0;
    #1;
    n_chk++;
    if (dut_vec !== 8'h00)
      $display("FAIL areset_immediate: got %b want %b", dut_vec, 8'h00);
    else n_pass++;
    #4;
    reset_n = 1;
    fence = 0; wb_v = 0; ld_v = 0;
    m_mode = 0; m_den = 0;
    step(0, 1, 0, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0101_0000)
      $display("FAIL areset_after: got %b want %b", act_v, 8'b0101_0000);
    else n_pass++;
    step(0, 1, 1, 0, 0, 0);
    n_chk++;
    if (act_v !== 8'b0101_0000)
      $display("FAIL areset_ready: got %b want %b", act_v, 8'b0101_0000);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic fv = 0;
    for (int i = 0; i < 600; i++) begin
      logic e, l, w, f, s;
      e = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 4) != 0);
      f = w && ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 7) == 0);
      if (!fv && $urandom_range(0, 24) == 0) fv = 1;
      step(e, l, w, f, s, fv);
      n_chk++;
      if (act_v !== exp_v)
        $display("FAIL random_c%0d: got %b want %b", i, act_v, exp_v);
      else n_pass++;
      if (exp_v[0]) fv = 0;
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_engine_priority();
    test_starvation();
    test_force();
    test_snoop();
    test_fence();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
